// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: state codes,
// opcodes and the encodings of every datapath select it drives.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JALR     = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ERROR    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// mux selects and write strobes out.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCUpdate;
  logic       Branch;
  logic       RegWrite;
  logic       MemWrite;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal, state_o
  );

  modport slave (
    output op, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal, state_o
  );
endinterface

// File: rtl/mc_control_fsm_imm_src_dec.sv
// Immediate-format decoder: picks the ImmSrc encoding straight from the
// opcode, independent of controller state.
module imm_src_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LOAD, OP_JALR, OP_I: imm_src = IMM_I;
      OP_STORE:               imm_src = IMM_S;
      OP_BRANCH:              imm_src = IMM_B;
      OP_JAL:                 imm_src = IMM_J;
      OP_LUI, OP_AUIPC:       imm_src = IMM_U;
      default:                imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/writeback and driving the datapath.
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_fsm_if.master bus
);

  state_t     state_reg;
  state_t     out_state;
  logic [1:0] alu_op, src_a, src_b, res_src;
  logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:    if (bus.mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
            OP_R:              state_reg <= S_EXECR;
            OP_I:              state_reg <= S_EXECI;
            OP_JAL:            state_reg <= S_JAL;
            OP_JALR:           state_reg <= S_JALR;
            OP_BRANCH:         state_reg <= S_BRANCH;
            OP_LUI:            state_reg <= S_LUI;
            OP_AUIPC:          state_reg <= S_AUIPC;
            default:           state_reg <= S_ERROR;
          endcase
        end
        S_MEMADR:   state_reg <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state_reg <= S_MEMWB;
        S_MEMWB:    state_reg <= S_FETCH;
        S_MEMWRITE: if (bus.mem_ready) state_reg <= S_FETCH;
        S_EXECR:    state_reg <= S_ALUWB;
        S_EXECI:    state_reg <= S_ALUWB;
        S_ALUWB:    state_reg <= S_FETCH;
        // jalr reuses the jal state to write PC and form the link value
        S_JALR:     state_reg <= S_JAL;
        S_JAL:      state_reg <= S_ALUWB;
        S_BRANCH:   state_reg <= S_FETCH;
        S_LUI:      state_reg <= S_ALUWB;
        S_AUIPC:    state_reg <= S_ALUWB;
        S_ERROR:    if (!ERR_STICKY) state_reg <= S_FETCH;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  // During reset the outputs look like fetch with every strobe suppressed.
  assign out_state = reset ? S_FETCH : state_reg;

  always_comb begin
    alu_op    = ALUOP_ADD;
    src_a     = SRCA_PC;
    src_b     = SRCB_RD2;
    res_src   = RES_ALUOUT;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (out_state)
      S_FETCH: begin
        src_b     = SRCB_FOUR;
        res_src   = RES_ALURESULT;
        ir_write  = bus.mem_ready;
        pc_update = bus.mem_ready;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR, S_EXECI, S_JALR: begin
        src_a  = SRCA_RD1;
        src_b  = SRCB_IMM;
        alu_op = (out_state == S_EXECI) ? ALUOP_FUNCT : ALUOP_ADD;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        res_src   = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RD1;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        src_a  = SRCA_RD1;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
      end
      S_LUI: begin
        src_a = SRCA_ZERO;
        src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_ERROR: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  imm_src_dec u_imm_src_dec (
    .op      (bus.op),
    .imm_src (bus.ImmSrc)
  );

  assign bus.ALUOp     = alu_op;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = res_src;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCUpdate  = pc_update;
  assign bus.Branch    = branch;
  assign bus.RegWrite  = reg_write;
  assign bus.MemWrite  = mem_write;
  assign bus.illegal   = illegal;
  assign bus.state_o   = out_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-instruction cycle-trace model feeds a
// scoreboard that a negedge monitor checks against both error-mode variants.
module tb_mc_control_fsm;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] alu, srca, srcb, res;
    logic [2:0] imm;
    logic       adr, irw, pcu, br, rw, mw, ill;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       mr;
    exp_t       e;
    exp_t       ens;
  } step_t;

  typedef struct packed {
    exp_t e;
    exp_t ens;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus();
  mc_control_fsm_if bus_ns();
  assign bus_ns.op        = bus.op;
  assign bus_ns.mem_ready = bus.mem_ready;

  mc_control_fsm #(.ERR_STICKY(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  mc_control_fsm #(.ERR_STICKY(1'b0)) u_dut_ns (.clk(clk), .reset(reset), .bus(bus_ns));

  step_t plan[$];
  pair_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_STORE) return 3'b001;
    if (op == OP_BRANCH) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic exp_t rec(input state_t st, input logic [1:0] alu, a, b, res,
                               input logic adr, irw, pcu, br, rw, mw, ill,
                               input logic [6:0] op);
    exp_t r;
    r.st = st; r.alu = alu; r.srca = a; r.srcb = b; r.res = res;
    r.imm = imm_of(op); r.adr = adr; r.irw = irw; r.pcu = pcu;
    r.br = br; r.rw = rw; r.mw = mw; r.ill = ill;
    return r;
  endfunction

  function automatic exp_t fetch_rec(input logic [6:0] op, input logic ready);
    return rec(S_FETCH, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, ready, ready, 1'b0, 1'b0, 1'b0, 1'b0, op);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic [6:0] op, input logic mr,
                      input exp_t e, input exp_t ens);
    step_t s;
    s.rst = rst; s.op = op; s.mr = mr; s.e = e; s.ens = ens;
    plan.push_back(s);
  endtask

  task automatic push1(input logic [6:0] op, input logic mr, input exp_t e);
    push(1'b0, op, mr, e, e);
  endtask

  task automatic add_reset(input logic [6:0] op, input int n);
    for (int i = 0; i < n; i++) push(1'b1, op, 1'b1, fetch_rec(op, 1'b0), fetch_rec(op, 1'b0));
  endtask

  // Expected cycle trace of one instruction, from the per-class cycle recipe.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input int abort);
    int start;
    exp_t err;
    start = plan.size();
    for (int i = 0; i < fw; i++) push1(op, 1'b0, fetch_rec(op, 1'b0));
    push1(op, 1'b1, fetch_rec(op, 1'b1));
    push1(op, rbit(), rec(S_DECODE, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, op));
    if (op == OP_LOAD) begin
      push1(op, rbit(), rec(S_MEMADR, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, op));
      for (int i = 0; i < mw; i++) push1(op, 1'b0, rec(S_MEMREAD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, op));
      push1(op, 1'b1, rec(S_MEMREAD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, op));
      push1(op, rbit(), rec(S_MEMWB, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, op));
    end else if (op == OP_STORE) begin
      push1(op, rbit(), rec(S_MEMADR, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, op));
      for (int i = 0; i < mw; i++) push1(op, 1'b0, rec(S_MEMWRITE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, op));
      push1(op, 1'b1, rec(S_MEMWRITE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, op));
    end else if (op == OP_BRANCH) begin
      push1(op, rbit(), rec(S_BRANCH, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, op));
    end else if (op == OP_R || op == OP_I || op == OP_JAL || op == OP_JALR ||
                 op == OP_LUI || op == OP_AUIPC) begin
      if (op == OP_R)     push1(op, rbit(), rec(S_EXECR, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, op));
      if (op == OP_I)     push1(op, rbit(), rec(S_EXECI, 2'b10, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, op));
      if (op == OP_LUI)   push1(op, rbit(), rec(S_LUI, 2'b00, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, op));
      if (op == OP_AUIPC) push1(op, rbit(), rec(S_AUIPC, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, op));
      if (op == OP_JALR)  push1(op, rbit(), rec(S_JALR, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, op));
      if (op == OP_JAL || op == OP_JALR)
        push1(op, rbit(), rec(S_JAL, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0, 0, op));
      push1(op, rbit(), rec(S_ALUWB, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, op));
    end else begin
      // Illegal: sticky part holds error; the other pulses once and idles in fetch.
      err = rec(S_ERROR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, op);
      push(1'b0, op, 1'b0, err, err);
      for (int i = 0; i < 9; i++) push(1'b0, op, 1'b0, err, fetch_rec(op, 1'b0));
      add_reset(op, 2);
      return;
    end
    if (abort > 0 && plan.size() - start > abort) begin
      while (plan.size() > start + abort) void'(plan.pop_back());
      add_reset(op, 2);
    end
  endtask

  exp_t  act, act_ns;
  pair_t cur;

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {bus.state_o, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
             bus.AdrSrc, bus.IRWrite, bus.PCUpdate, bus.Branch, bus.RegWrite, bus.MemWrite,
             bus.illegal};
      act_ns = {bus_ns.state_o, bus_ns.ALUOp, bus_ns.ALUSrcA, bus_ns.ALUSrcB, bus_ns.ResultSrc,
                bus_ns.ImmSrc, bus_ns.AdrSrc, bus_ns.IRWrite, bus_ns.PCUpdate, bus_ns.Branch,
                bus_ns.RegWrite, bus_ns.MemWrite, bus_ns.illegal};
      checks++;
      if (act !== cur.e) begin
        failures++;
        $display("FAIL sticky_outputs cyc=%0d op=%b got=%h want=%h", cyc, bus.op, act, cur.e);
      end
      checks++;
      if (act_ns !== cur.ens) begin
        failures++;
        $display("FAIL nonsticky_outputs cyc=%0d op=%b got=%h want=%h", cyc, bus.op, act_ns, cur.ens);
      end
      $display("cyc=%0d rst=%0b op=%b mr=%0b state=%0d", cyc, reset, bus.op, bus.mem_ready, act.st);
    end
  end

  initial begin
    logic [6:0] legal [9];
    logic [6:0] op;
    pair_t p;
    bit is_legal;
    legal = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    bus.op = 7'd0;
    bus.mem_ready = 1'b1;
    reset = 1'b1;

    add_reset(7'd0, 2);
    add_instr(OP_R, 0, 0, 0);
    add_instr(OP_LOAD, 0, 3, 0);
    add_instr(OP_STORE, 0, 1, 0);
    add_instr(OP_JALR, 0, 0, 0);
    add_instr(7'b1111111, 0, 0, 0);
    add_instr(OP_BRANCH, 2, 0, 0);
    add_instr(OP_LUI, 1, 0, 3);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do begin
          op = 7'($urandom_range(0, 127));
          is_legal = 1'b0;
          foreach (legal[k]) if (legal[k] == op) is_legal = 1'b1;
        end while (is_legal);
        add_instr(op, $urandom_range(0, 2), 0, 0);
      end else begin
        op = legal[$urandom_range(0, 8)];
        add_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0);
      end
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset = plan[i].rst;
      bus.op = plan[i].op;
      bus.mem_ready = plan[i].mr;
      p.e = plan[i].e;
      p.ens = plan[i].ens;
      sb.push_back(p);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
